// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data RAM port arbiter (mem_port_arbiter).
package mem_arb_pkg;

  localparam int MEM_ARB_CNT_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_D  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port RAM request/response bundle; master = arbiter side, slave = RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_perf.sv
// Wrapping grant/conflict counters for mem_port_arbiter; compiled only with MEM_ARB_PERF_EN.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     n_rst,
  input  logic                     if_gnt_i,
  input  logic                     d_gnt_i,
  input  logic                     conflict_i,
  output logic [MEM_ARB_CNT_W-1:0] perf_if_cnt_o,
  output logic [MEM_ARB_CNT_W-1:0] perf_d_cnt_o,
  output logic [MEM_ARB_CNT_W-1:0] perf_conflict_cnt_o
);
  logic [MEM_ARB_CNT_W-1:0] if_cnt_q, if_cnt_d;
  logic [MEM_ARB_CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [MEM_ARB_CNT_W-1:0] cf_cnt_q, cf_cnt_d;

  always_comb begin
    if_cnt_d = if_cnt_q + MEM_ARB_CNT_W'(if_gnt_i);
    d_cnt_d  = d_cnt_q  + MEM_ARB_CNT_W'(d_gnt_i);
    cf_cnt_d = cf_cnt_q + MEM_ARB_CNT_W'(conflict_i);
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      if_cnt_q <= '0;
      d_cnt_q  <= '0;
      cf_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      d_cnt_q  <= d_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign perf_if_cnt_o       = if_cnt_q;
  assign perf_d_cnt_o        = d_cnt_q;
  assign perf_conflict_cnt_o = cf_cnt_q;
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared instruction/data RAM port; one transaction in flight.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                n_rst,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
`ifdef MEM_ARB_PERF_EN
  output logic [MEM_ARB_CNT_W-1:0] perf_if_cnt_o,
  output logic [MEM_ARB_CNT_W-1:0] perf_d_cnt_o,
  output logic [MEM_ARB_CNT_W-1:0] perf_conflict_cnt_o,
`endif
  mem_port_arbiter_if.master  mem
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q, state_d;
  arb_owner_t owner;
  logic [SW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic          idle, starved;

  // Owner is only ever non-none out of reset, which gates every request-side output.
  always_comb begin
    idle    = (state_q == ARB_IDLE);
    starved = (starve_q == SW'(STARVE_LIMIT));
    owner   = OWN_NONE;
    if (idle && n_rst) begin
      if (if_req_i && !flush_i && (!d_req_i || starved)) owner = OWN_IF;
      else if (d_req_i)                                   owner = OWN_D;
    end
  end

  always_comb begin
    mem.req   = (owner != OWN_NONE);
    mem.we    = 1'b0;
    mem.be    = '0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (owner == OWN_IF) begin
      mem.be   = '1;
      mem.addr = if_addr_i;
    end else if (owner == OWN_D) begin
      mem.we    = d_we_i;
      mem.be    = d_be_i;
      mem.addr  = d_addr_i;
      mem.wdata = d_wdata_i;
    end
    if_gnt_o = (owner == OWN_IF) && mem.gnt;
    d_gnt_o  = (owner == OWN_D)  && mem.gnt;
  end

  // A flush coinciding with the response cancels it directly; drop_q covers earlier flushes.
  always_comb begin
    if_rvalid_o = n_rst && (state_q == ARB_WAIT_IF) && mem.rvalid && !drop_q && !flush_i;
    d_rvalid_o  = n_rst && (state_q == ARB_WAIT_D)  && mem.rvalid;
    if_rdata_o  = if_rvalid_o ? mem.rdata : '0;
    d_rdata_o   = d_rvalid_o  ? mem.rdata : '0;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    unique case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (if_gnt_o) begin
          state_d  = ARB_WAIT_IF;
          starve_d = '0;
        end else if (d_gnt_o) begin
          state_d  = ARB_WAIT_D;
          starve_d = !if_req_i ? '0 : (starved ? starve_q : starve_q + SW'(1));
        end
      end
      ARB_WAIT_IF: begin
        if (flush_i) drop_d = 1'b1;
        if (mem.rvalid) begin
          state_d = ARB_IDLE;
          drop_d  = 1'b0;
        end
      end
      ARB_WAIT_D: begin
        if (mem.rvalid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk_i               (clk_i),
    .n_rst               (n_rst),
    .if_gnt_i            (if_gnt_o),
    .d_gnt_i             (d_gnt_o),
    .conflict_i          (idle && if_req_i && d_req_i),
    .perf_if_cnt_o       (perf_if_cnt_o),
    .perf_d_cnt_o        (perf_d_cnt_o),
    .perf_conflict_cnt_o (perf_conflict_cnt_o)
  );
`endif
endmodule
